// File: rtl/axi_tb_pkg.sv
// ----------------------------------------------------------------------------
// axi_tb_pkg
// Shared definitions for the AXI read-request generator slice:
//   - AXI response encodings
//   - rd_req_t: one outstanding read burst (beats-1 and ID)
//   - bit indices of the sticky error vector
//   - FSM state type of the AR issue path
// ----------------------------------------------------------------------------
package axi_tb_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // IDs are stored zero-extended to this width, so any AXI_ID_W up to
    // this value shares one tracking record type.
    localparam int unsigned RD_REQ_ID_W = 16;

    typedef struct packed {
        logic [3:0]             len;
        logic [RD_REQ_ID_W-1:0] id;
    } rd_req_t;

    localparam int unsigned ERR_RESP  = 0;
    localparam int unsigned ERR_ID    = 1;
    localparam int unsigned ERR_UNEXP = 2;
    localparam int unsigned ERR_LAST  = 3;

    typedef enum logic {
        ST_IDLE,
        ST_ADDR
    } mst_state_e;

endpackage

// File: rtl/axi_ostd_fifo.sv
// ----------------------------------------------------------------------------
// axi_ostd_fifo
// In-order tracking FIFO for outstanding read bursts.
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   push, push_data write one entry (ignored when full unless popping)
//   pop             retire the head entry (ignored when empty)
//   head            oldest entry (valid when !empty)
//   full, empty     occupancy flags
// Same-cycle push and pop are allowed whenever the FIFO is not empty.
// DEPTH must be a power of two, >= 2.
// ----------------------------------------------------------------------------
module axi_ostd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic [7:0]
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_mst_rd_gen.sv
// ----------------------------------------------------------------------------
// axi_mst_rd_gen
// AXI3-style read-request generator. Converts a command stream into INCR AR
// bursts, consumes R beats, tracks outstanding bursts in order and raises
// sticky error flags.
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   in_cmd_*/out_cmd_ready        command stream (addr, len = beats-1, id)
//   out_ar*/in_arready            AR channel
//   in_r*/out_rready              R channel; in_rstall requests back-pressure
//   out_rd_ostd                   bursts accepted on AR but not yet retired
//   out_done_cnt                  retired bursts, wrapping
//   out_err                       sticky: [0] resp!=OKAY, [1] id mismatch,
//                                 [2] beat with nothing outstanding,
//                                 [3] rlast misplaced
// Build option AXI_MST_RLAST_CHK_EN:
//   defined   -> bursts retire on beat count, rlast placement is checked
//   undefined -> bursts retire on the rlast beat, err[3] is tied 0
// ----------------------------------------------------------------------------
module axi_mst_rd_gen
    import axi_tb_pkg::*;
#(
    parameter int unsigned AXI_ADDR_W      = 32,
    parameter int unsigned AXI_ID_W        = 4,
    parameter int unsigned MST_OSTDREQ_NUM = 4,
    parameter int unsigned DONE_CNT_W      = 16
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                in_cmd_valid,
    output logic                                out_cmd_ready,
    input  logic [AXI_ADDR_W-1:0]               in_cmd_addr,
    input  logic [3:0]                          in_cmd_len,
    input  logic [AXI_ID_W-1:0]                 in_cmd_id,
    output logic                                out_arvalid,
    input  logic                                in_arready,
    output logic [AXI_ADDR_W-1:0]               out_araddr,
    output logic [3:0]                          out_arlen,
    output logic [AXI_ID_W-1:0]                 out_arid,
    input  logic                                in_rvalid,
    output logic                                out_rready,
    input  logic [AXI_ID_W-1:0]                 in_rid,
    input  logic [1:0]                          in_rresp,
    input  logic                                in_rlast,
    input  logic                                in_rstall,
    output logic [$clog2(MST_OSTDREQ_NUM):0]    out_rd_ostd,
    output logic [DONE_CNT_W-1:0]               out_done_cnt,
    output logic [3:0]                          out_err
);

    mst_state_e state;
    logic       cmd_hs;
    logic       ar_hs;
    logic       beat;
    logic       head_beat;
    logic       at_last;
    logic       retire;
    logic       last_err;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] beat_cnt;
    rd_req_t    push_req;
    rd_req_t    head_req;
    logic [RD_REQ_ID_W-1:0] rid_ext;

    // FIFO occupancy always equals out_rd_ostd, so its flags stand in for
    // the rd_ostd<N and rd_ostd!=0 tests.
    assign out_cmd_ready = (state == ST_IDLE) & ~fifo_full;
    assign cmd_hs        = in_cmd_valid & out_cmd_ready;
    assign ar_hs         = out_arvalid & in_arready;
    assign beat          = in_rvalid & out_rready;
    assign head_beat     = beat & ~fifo_empty;
    assign rid_ext       = RD_REQ_ID_W'(in_rid);
    assign at_last       = (beat_cnt == head_req.len);

`ifdef AXI_MST_RLAST_CHK_EN
    assign retire   = head_beat & at_last;
    assign last_err = head_beat & (in_rlast != at_last);
`else
    assign retire   = head_beat & in_rlast;
    assign last_err = 1'b0;
`endif

    assign push_req.len = out_arlen;
    assign push_req.id  = RD_REQ_ID_W'(out_arid);

    axi_ostd_fifo #(
        .DEPTH (MST_OSTDREQ_NUM),
        .T     (rd_req_t)
    ) u_ostd_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (ar_hs),
        .push_data (push_req),
        .pop       (retire),
        .head      (head_req),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // AR issue FSM; AR outputs hold steady while waiting for arready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            out_arvalid <= 1'b0;
            out_araddr  <= '0;
            out_arlen   <= '0;
            out_arid    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        out_araddr  <= in_cmd_addr;
                        out_arlen   <= in_cmd_len;
                        out_arid    <= in_cmd_id;
                        out_arvalid <= 1'b1;
                        state       <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (in_arready) begin
                        out_arvalid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    out_arvalid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // R tracking: beats with nothing outstanding only raise err[2].
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_rready   <= 1'b0;
            out_rd_ostd  <= '0;
            out_done_cnt <= '0;
            out_err      <= '0;
            beat_cnt     <= '0;
        end else begin
            out_rready <= ~in_rstall;

            case ({ar_hs, retire})
                2'b10:   out_rd_ostd <= out_rd_ostd + 1'b1;
                2'b01:   out_rd_ostd <= out_rd_ostd - 1'b1;
                default: out_rd_ostd <= out_rd_ostd;
            endcase

            if (retire) begin
                beat_cnt     <= '0;
                out_done_cnt <= out_done_cnt + 1'b1;
            end else if (head_beat) begin
                beat_cnt <= beat_cnt + 4'd1;
            end

            if (head_beat) begin
                if (in_rresp != AXI_RESP_OKAY) out_err[ERR_RESP] <= 1'b1;
                if (rid_ext != head_req.id)    out_err[ERR_ID]   <= 1'b1;
            end
            if (beat & fifo_empty) out_err[ERR_UNEXP] <= 1'b1;
            if (last_err)          out_err[ERR_LAST]  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_mst_rd_gen.sv
module tb_axi_mst_rd_gen;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        in_cmd_valid = 1'b0;
    logic        out_cmd_ready;
    logic [31:0] in_cmd_addr = '0;
    logic [3:0]  in_cmd_len = '0;
    logic [3:0]  in_cmd_id = '0;
    logic        out_arvalid;
    logic        in_arready = 1'b1;
    logic [31:0] out_araddr;
    logic [3:0]  out_arlen;
    logic [3:0]  out_arid;
    logic        in_rvalid = 1'b0;
    logic        out_rready;
    logic [3:0]  in_rid = '0;
    logic [1:0]  in_rresp = '0;
    logic        in_rlast = 1'b0;
    logic        in_rstall = 1'b0;
    logic [2:0]  out_rd_ostd;
    logic [15:0] out_done_cnt;
    logic [3:0]  out_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    axi_mst_rd_gen #(
        .AXI_ADDR_W      (32),
        .AXI_ID_W        (4),
        .MST_OSTDREQ_NUM (4),
        .DONE_CNT_W      (16)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .in_cmd_valid  (in_cmd_valid),
        .out_cmd_ready (out_cmd_ready),
        .in_cmd_addr   (in_cmd_addr),
        .in_cmd_len    (in_cmd_len),
        .in_cmd_id     (in_cmd_id),
        .out_arvalid   (out_arvalid),
        .in_arready    (in_arready),
        .out_araddr    (out_araddr),
        .out_arlen     (out_arlen),
        .out_arid      (out_arid),
        .in_rvalid     (in_rvalid),
        .out_rready    (out_rready),
        .in_rid        (in_rid),
        .in_rresp      (in_rresp),
        .in_rlast      (in_rlast),
        .in_rstall     (in_rstall),
        .out_rd_ostd   (out_rd_ostd),
        .out_done_cnt  (out_done_cnt),
        .out_err       (out_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a command from a negedge; returns at the negedge after handshake.
    task automatic send_cmd(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id);
        int unsigned w = 0;
        in_cmd_addr  = addr;
        in_cmd_len   = len;
        in_cmd_id    = id;
        in_cmd_valid = 1'b1;
        while (!out_cmd_ready && w < 20) begin
            @(negedge aclk);
            w++;
        end
        chk("cmd_ready_wait", 32'(out_cmd_ready), 32'd1);
        @(negedge aclk);
        in_cmd_valid = 1'b0;
    endtask

    // One R beat, assumes out_rready is high for the coming edge.
    task automatic beat(input logic [3:0] id, input logic [1:0] resp, input logic last);
        in_rvalid = 1'b1;
        in_rid    = id;
        in_rresp  = resp;
        in_rlast  = last;
        @(negedge aclk);
        in_rvalid = 1'b0;
        in_rlast  = 1'b0;
        in_rresp  = 2'b00;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        chk("rst_arvalid", 32'(out_arvalid), 32'd0);
        chk("rst_araddr", out_araddr, 32'd0);
        chk("rst_arlen", 32'(out_arlen), 32'd0);
        chk("rst_arid", 32'(out_arid), 32'd0);
        chk("rst_rready", 32'(out_rready), 32'd0);
        chk("rst_ostd", 32'(out_rd_ostd), 32'd0);
        chk("rst_done", 32'(out_done_cnt), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_cmd_ready", 32'(out_cmd_ready), 32'd1);
        chk("rst_rready_up", 32'(out_rready), 32'd1);
    endtask

    initial begin
        logic        exp_rready;
        int unsigned nb;
        int unsigned k;
        logic [3:0]  e_last;

        @(negedge aclk);
        do_reset();

        // 1: single burst len=3 id=5
        send_cmd(32'h100, 4'd3, 4'd5);
        chk("t1_arvalid", 32'(out_arvalid), 32'd1);
        chk("t1_araddr", out_araddr, 32'h100);
        chk("t1_arlen", 32'(out_arlen), 32'd3);
        chk("t1_arid", 32'(out_arid), 32'd5);
        chk("t1_cmd_ready_addr", 32'(out_cmd_ready), 32'd0);
        @(negedge aclk);
        chk("t1_arvalid_drop", 32'(out_arvalid), 32'd0);
        chk("t1_ostd1", 32'(out_rd_ostd), 32'd1);
        beat(4'd5, 2'b00, 1'b0);
        beat(4'd5, 2'b00, 1'b0);
        beat(4'd5, 2'b00, 1'b0);
        chk("t1_ostd_mid", 32'(out_rd_ostd), 32'd1);
        chk("t1_done_mid", 32'(out_done_cnt), 32'd0);
        beat(4'd5, 2'b00, 1'b1);
        chk("t1_done", 32'(out_done_cnt), 32'd1);
        chk("t1_ostd0", 32'(out_rd_ostd), 32'd0);
        chk("t1_err", 32'(out_err), 32'd0);

        // 2: fill to N outstanding, fifth command waits for a retire
        for (int i = 0; i < 4; i++) begin
            send_cmd(32'h1000 + 32'(i) * 32'h10, 4'd0, 4'(i + 1));
            @(negedge aclk);
        end
        chk("t2_ostd_full", 32'(out_rd_ostd), 32'd4);
        chk("t2_cmd_ready_full", 32'(out_cmd_ready), 32'd0);
        in_cmd_addr  = 32'h1040;
        in_cmd_len   = 4'd0;
        in_cmd_id    = 4'd5;
        in_cmd_valid = 1'b1;
        repeat (2) begin
            @(negedge aclk);
            chk("t2_cmd_blocked", 32'(out_cmd_ready), 32'd0);
            chk("t2_no_ar", 32'(out_arvalid), 32'd0);
        end
        beat(4'd1, 2'b00, 1'b1);
        chk("t2_ostd3", 32'(out_rd_ostd), 32'd3);
        chk("t2_cmd_ready_back", 32'(out_cmd_ready), 32'd1);
        chk("t2_done", 32'(out_done_cnt), 32'd2);
        @(negedge aclk);
        in_cmd_valid = 1'b0;
        chk("t2_ar5_valid", 32'(out_arvalid), 32'd1);
        chk("t2_ar5_id", 32'(out_arid), 32'd5);
        chk("t2_ar5_addr", out_araddr, 32'h1040);
        @(negedge aclk);
        chk("t2_ostd_refill", 32'(out_rd_ostd), 32'd4);
        beat(4'd2, 2'b00, 1'b1);
        beat(4'd3, 2'b00, 1'b1);
        beat(4'd4, 2'b00, 1'b1);
        beat(4'd5, 2'b00, 1'b1);
        chk("t2_drain_ostd", 32'(out_rd_ostd), 32'd0);
        chk("t2_drain_done", 32'(out_done_cnt), 32'd6);
        chk("t2_err", 32'(out_err), 32'd0);

        // 3: arready held low for 3 cycles
        in_arready = 1'b0;
        send_cmd(32'h200, 4'd2, 4'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t3_arvalid_hold", 32'(out_arvalid), 32'd1);
            chk("t3_araddr_hold", out_araddr, 32'h200);
            chk("t3_arlen_hold", 32'(out_arlen), 32'd2);
            chk("t3_arid_hold", 32'(out_arid), 32'd3);
            chk("t3_ostd_hold", 32'(out_rd_ostd), 32'd0);
            @(negedge aclk);
        end
        in_arready = 1'b1;
        @(negedge aclk);
        chk("t3_arvalid_drop", 32'(out_arvalid), 32'd0);
        chk("t3_ostd1", 32'(out_rd_ostd), 32'd1);

        // 4: rstall toggled each cycle, rvalid held, rready lags by one cycle
        exp_rready = 1'b1;
        nb = 0;
        k  = 0;
        while (nb < 3 && k < 20) begin
            chk("t4_rready_lag", 32'(out_rready), 32'(exp_rready));
            in_rvalid = 1'b1;
            in_rid    = 4'd3;
            in_rlast  = (nb == 2);
            in_rstall = (k % 2 == 1);
            if (exp_rready) nb++;
            exp_rready = ~in_rstall;
            k++;
            @(negedge aclk);
        end
        in_rvalid = 1'b0;
        in_rlast  = 1'b0;
        in_rstall = 1'b0;
        chk("t4_beats_seen", nb, 32'd3);
        chk("t4_cycles", k, 32'd4);
        chk("t4_done", 32'(out_done_cnt), 32'd7);
        chk("t4_ostd0", 32'(out_rd_ostd), 32'd0);
        chk("t4_err", 32'(out_err), 32'd0);
        @(negedge aclk);
        chk("t4_rready_restore", 32'(out_rready), 32'd1);

        // 5: error injection
        send_cmd(32'h300, 4'd1, 4'd5);
        @(negedge aclk);
        beat(4'd2, 2'b00, 1'b0);
        chk("t5_err_id", 32'(out_err), 32'h2);
        beat(4'd5, 2'b10, 1'b1);
        chk("t5_err_resp", 32'(out_err), 32'h3);
        chk("t5_done", 32'(out_done_cnt), 32'd8);
        chk("t5_ostd0", 32'(out_rd_ostd), 32'd0);
        beat(4'd0, 2'b00, 1'b1);
        chk("t5_err_unexp", 32'(out_err), 32'h7);
        chk("t5_unexp_done", 32'(out_done_cnt), 32'd8);
        chk("t5_unexp_ostd", 32'(out_rd_ostd), 32'd0);

        // 6: early rlast on beat 1 of len=3
        send_cmd(32'h400, 4'd3, 4'd6);
        @(negedge aclk);
        beat(4'd6, 2'b00, 1'b0);
        beat(4'd6, 2'b00, 1'b1);
`ifdef AXI_MST_RLAST_CHK_EN
        e_last = 4'hF;
        chk("t6_err_last", 32'(out_err), 32'hF);
        chk("t6_ostd_held", 32'(out_rd_ostd), 32'd1);
        chk("t6_done_held", 32'(out_done_cnt), 32'd8);
        beat(4'd6, 2'b00, 1'b0);
        beat(4'd6, 2'b00, 1'b1);
`else
        e_last = 4'h7;
        chk("t6_err_nolast", 32'(out_err), 32'h7);
`endif
        chk("t6_ostd0", 32'(out_rd_ostd), 32'd0);
        chk("t6_done", 32'(out_done_cnt), 32'd9);

        // 6b: AR handshake and retire in the same cycle at rd_ostd=2
        send_cmd(32'h500, 4'd0, 4'd7);
        @(negedge aclk);
        send_cmd(32'h510, 4'd0, 4'd8);
        @(negedge aclk);
        chk("t6b_ostd2", 32'(out_rd_ostd), 32'd2);
        in_arready = 1'b0;
        send_cmd(32'h520, 4'd0, 4'd9);
        chk("t6b_ar_pending", 32'(out_arvalid), 32'd1);
        in_arready = 1'b1;
        beat(4'd7, 2'b00, 1'b1);
        chk("t6b_ostd_same", 32'(out_rd_ostd), 32'd2);
        chk("t6b_ar_done", 32'(out_arvalid), 32'd0);
        chk("t6b_done", 32'(out_done_cnt), 32'd10);
        beat(4'd8, 2'b00, 1'b1);
        beat(4'd9, 2'b00, 1'b1);
        chk("t6b_ostd0", 32'(out_rd_ostd), 32'd0);
        chk("t6b_done_end", 32'(out_done_cnt), 32'd12);
        chk("t6b_err_sticky", 32'(out_err), 32'(e_last));

        // 7: reset mid-burst, leftover beat is unexpected
        send_cmd(32'h600, 4'd3, 4'd1);
        @(negedge aclk);
        beat(4'd1, 2'b00, 1'b0);
        chk("t7_ostd1", 32'(out_rd_ostd), 32'd1);
        do_reset();
        beat(4'd1, 2'b00, 1'b0);
        chk("t7_err_unexp", 32'(out_err), 32'h4);
        chk("t7_ostd0", 32'(out_rd_ostd), 32'd0);
        chk("t7_done0", 32'(out_done_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
